ram16k_core: RTL and testbench
==============================

// Module: ram16k_core
// PURPOSE
//  16384 x 16-bit data memory (Hack-style RAM16K): one write port, one asynchronous read port.
//  Sits in the CPU data path; the CPU drives one address for both reading and writing.
//  Organised as 4 banks of 4K words selected by address[13:12].
//  Async active-low reset logically clears the whole array.
// PARAMETERS
//  DATA_W  16     word width in bits
//  ADDR_W  14     address width; depth = 2**ADDR_W = 16384
//  BANK_W  2      bank-select bits taken from the address MSBs; 4 banks of 4096 words
// PORTS
//  clk      in   1       clock; writes occur on the rising edge
//  rst_n    in   1       asynchronous active-low reset
//  in       in   16      write data
//  load     in   1       write enable, active high
//  address  in   14      word address for both read and write
//  out      out  16      read data = contents of word[address]
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low.
//  - Write: at posedge clk with rst_n=1 and load=1, word[address] <= in.
//    With load=0 the array is unchanged.
//  - Read: out is combinational from address and the array contents, with no clock latency.
//    After a write edge, out shows the new value in the same cycle, with only delta delay.
//  - Read-during-write: before the edge, out shows the old word; after the edge, the new word.
//    There is no write-through of in before the edge.
//  - Reset: while rst_n=0, every word reads as 0 and writes are ignored.
//    Implementation: a per-word valid bit, 16384 flops, asynchronously cleared.
//    out = valid[address] ? mem[address] : 16'd0.
//    A write sets valid[address]=1. The data array itself needs no reset.
//  - Reset release: only words written after release read non-zero.
//    Reset asserted mid-operation clears everything immediately; out drops to 0 without waiting for clk.
//  - Bank decode: bank = address[13:12], offset = address[11:0].
//    Only the selected bank sees the write enable. out is muxed from the selected bank.
//  - Width rules: there is no address wrap and no out-of-range case; all 14-bit addresses are valid.
//    Data is stored unmodified.
//  - X handling: the bank mux defines out for every defined address.
//    X or Z on load may corrupt only the addressed word.
// TESTING
//  1. rst_n 0->1, no writes; sweep addresses 0, 5, 4095, 4096, 16383 -> out=0 at each.
//  2. in=3, load=1, address=5 across one posedge -> out=3 right after the edge.
//     Then load=0, in=9 for 2 edges -> out stays 3.
//  3. Bank isolation: write 0x1111@4095, 0x2222@4096, 0x3333@8192, 0xFFFF@16383.
//     Read all back -> exact values; address 0 still reads 0.
//  4. Same address, load=1, in changes 7->8 mid-cycle -> out=7 before the next edge, 8 after it.
//  5. Write 0xABCD@100, then pulse rst_n low between edges -> out=0 immediately.
//     After release, 100 still reads 0 until rewritten.
//  6. load=1 held with rst_n=0 across edges -> no word is written; all reads return 0 after release.

Source files
------------

// File: rtl/ram16k_core_if.sv
// Bus bundle for ram16k_core: write data, write enable, shared address, read data.
interface ram16k_core_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 14
);
  logic [DATA_W-1:0] in;
  logic              load;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] out;

  modport master (
    output in,
    output load,
    output address,
    input  out
  );

  modport slave (
    input  in,
    input  load,
    input  address,
    output out
  );
endinterface

// File: rtl/ram16k_core.sv
// 16K x 16 data memory built from 4 banks of 4K words.
// One synchronous write port, one combinational read port sharing one address.
// A per-word valid bit, cleared asynchronously, makes the array logically zero
// after reset without resetting the data storage itself.
module ram16k_core #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned BANK_W = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  ram16k_core_if.slave  bus
);

  localparam int unsigned OFF_W      = ADDR_W - BANK_W;
  localparam int unsigned NUM_BANKS  = 2 ** BANK_W;
  localparam int unsigned BANK_DEPTH = 2 ** OFF_W;

  logic [BANK_W-1:0]                 bank;
  logic [OFF_W-1:0]                  offset;
  logic [NUM_BANKS-1:0]              bank_we;
  logic [NUM_BANKS-1:0][DATA_W-1:0]  rd_data;
  logic [NUM_BANKS-1:0][BANK_DEPTH-1:0] valid_d;
  logic [NUM_BANKS-1:0][BANK_DEPTH-1:0] valid_q;

  // Split the address into bank select (MSBs) and in-bank offset.
  always_comb begin
    bank   = bus.address[ADDR_W-1 -: BANK_W];
    offset = bus.address[OFF_W-1:0];
  end

  // Route the write enable to the selected bank only; no writes while in reset.
  always_comb begin
    bank_we = '0;
    if (rst_n && bus.load) begin
      bank_we[bank] = 1'b1;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] mem [BANK_DEPTH];

    // Data storage: written on the clock edge, never reset.
    always_ff @(posedge clk) begin
      if (bank_we[b]) begin
        mem[offset] <= bus.in;
      end
    end

    always_comb rd_data[b] = mem[offset];
  end

  // Mark the addressed word valid when it is written.
  always_comb begin
    valid_d = valid_q;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (bank_we[b]) begin
        valid_d[b][offset] = 1'b1;
      end
    end
  end

  // Valid bits: cleared asynchronously, so every word reads zero the moment reset asserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Combinational read: selected bank's word, or zero if not written since reset.
  always_comb begin
    bus.out = '0;
    if (valid_q[bank][offset]) begin
      bus.out = rd_data[bank];
    end
  end

endmodule

// File: tb/tb_ram16k_core.sv
// Directed self-checking bench for ram16k_core.
module tb_ram16k_core;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  ram16k_core_if #(.DATA_W(16), .ADDR_W(14)) bus ();

  ram16k_core #(.DATA_W(16), .ADDR_W(14), .BANK_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a write on the next falling edge and hold it across one rising edge.
  task automatic drive_write(input logic [13:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.address = a;
    bus.in      = d;
    bus.load    = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [13:0] addrs [5];
    addrs = '{14'd0, 14'd5, 14'd4095, 14'd4096, 14'd16383};
    rst_n       = 1'b0;
    bus.load    = 1'b0;
    bus.in      = 16'h0;
    bus.address = 14'd0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.out !== 16'h0) begin
      bad++;
      $display("FAIL reset_hold: got %h want %h", bus.out, 16'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.address = addrs[i];
      #1;
      total++;
      if (bus.out !== 16'h0) begin
        bad++;
        $display("FAIL reset_sweep[%0d]: got %h want %h", addrs[i], bus.out, 16'h0);
      end
    end
  endtask

  task automatic test_write_hold;
    drive_write(14'd5, 16'd3);
    total++;
    if (bus.out !== 16'd3) begin
      bad++;
      $display("FAIL write_basic: got %h want %h", bus.out, 16'd3);
    end
    @(negedge clk);
    bus.load = 1'b0;
    bus.in   = 16'd9;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (bus.out !== 16'd3) begin
        bad++;
        $display("FAIL load_low_hold[%0d]: got %h want %h", i, bus.out, 16'd3);
      end
    end
  endtask

  task automatic test_bank_isolation;
    logic [13:0] addrs [5];
    logic [15:0] exp   [5];
    addrs = '{14'd4095, 14'd4096, 14'd8192, 14'd16383, 14'd0};
    exp   = '{16'h1111, 16'h2222, 16'h3333, 16'hFFFF, 16'h0000};
    for (int i = 0; i < 4; i++) drive_write(addrs[i], exp[i]);
    @(negedge clk);
    bus.load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.address = addrs[i];
      #1;
      total++;
      if (bus.out !== exp[i]) begin
        bad++;
        $display("FAIL bank_readback[%0d]: got %h want %h", addrs[i], bus.out, exp[i]);
      end
    end
  endtask

  task automatic test_read_during_write;
    @(negedge clk);
    bus.address = 14'd200;
    bus.in      = 16'd7;
    bus.load    = 1'b1;
    #1;
    total++;
    if (bus.out !== 16'd0) begin
      bad++;
      $display("FAIL no_write_through: got %h want %h", bus.out, 16'd0);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.out !== 16'd7) begin
      bad++;
      $display("FAIL rdw_first_edge: got %h want %h", bus.out, 16'd7);
    end
    @(negedge clk);
    bus.in = 16'd8;
    #1;
    total++;
    if (bus.out !== 16'd7) begin
      bad++;
      $display("FAIL rdw_before_edge: got %h want %h", bus.out, 16'd7);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.out !== 16'd8) begin
      bad++;
      $display("FAIL rdw_after_edge: got %h want %h", bus.out, 16'd8);
    end
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic test_async_reset;
    drive_write(14'd100, 16'hABCD);
    total++;
    if (bus.out !== 16'hABCD) begin
      bad++;
      $display("FAIL pre_reset_write: got %h want %h", bus.out, 16'hABCD);
    end
    @(negedge clk);
    bus.load = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.out !== 16'h0) begin
      bad++;
      $display("FAIL async_clear: got %h want %h", bus.out, 16'h0);
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (bus.out !== 16'h0) begin
      bad++;
      $display("FAIL post_release_100: got %h want %h", bus.out, 16'h0);
    end
    @(negedge clk);
    bus.address = 14'd4095;
    #1;
    total++;
    if (bus.out !== 16'h0) begin
      bad++;
      $display("FAIL post_release_4095: got %h want %h", bus.out, 16'h0);
    end
    drive_write(14'd100, 16'h1234);
    total++;
    if (bus.out !== 16'h1234) begin
      bad++;
      $display("FAIL rewrite_100: got %h want %h", bus.out, 16'h1234);
    end
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic test_load_in_reset;
    logic [13:0] addrs [4];
    addrs = '{14'd0, 14'd5, 14'd16383, 14'd9000};
    @(negedge clk);
    rst_n    = 1'b0;
    bus.load = 1'b1;
    bus.in   = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      bus.address = addrs[i];
      @(negedge clk);
    end
    bus.load = 1'b0;
    rst_n    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.address = addrs[i];
      #1;
      total++;
      if (bus.out !== 16'h0) begin
        bad++;
        $display("FAIL load_in_reset[%0d]: got %h want %h", addrs[i], bus.out, 16'h0);
      end
    end
    drive_write(14'd9000, 16'h0F0F);
    total++;
    if (bus.out !== 16'h0F0F) begin
      bad++;
      $display("FAIL write_after_release: got %h want %h", bus.out, 16'h0F0F);
    end
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_write_hold();
    test_bank_isolation();
    test_read_during_write();
    test_async_reset();
    test_load_in_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
